// File: rtl/e_4_pipo_dff.sv
// Single-bit D flip-flop with asynchronous active-low reset.
// RESET_BIT selects the value the bit takes while rst is low, so a
// multi-bit register can have an arbitrary reset word.
module e_4_pipo_dff #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  // Next-state: capture the data input unconditionally (no enable).
  always_comb begin
    q_d = d;
  end

  // State register: reset is asynchronous and has priority over the clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/e_4_pipo.sv
// Parallel-in/parallel-out holding register.
// Every rising clock edge loads the whole input word; the output is purely
// registered (one clock of latency, no combinational path from pi to po).
// Built as WIDTH independent bit cells so each bit gets its own reset value.
module e_4_pipo #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po
);

  // One flip-flop per bit; bit i of RESET_VALUE is that cell's reset bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    e_4_pipo_dff #(
      .RESET_BIT(RESET_VALUE[i])
    ) u_dff (
      .clk(clk),
      .rst(rst),
      .d  (pi[i]),
      .q  (po[i])
    );
  end

endmodule

// File: tb/tb_e_4_pipo.sv
// Bench for e_4_pipo: default 4-bit instance, a 4-bit instance with a
// non-zero reset word, and an 8-bit instance, all sharing clock and reset.
`timescale 1ns/100ps
module tb_e_4_pipo;

  localparam logic [3:0] RV = 4'b1001;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pi4;
  logic [3:0] po4;
  logic [3:0] po_rv;
  logic [7:0] pi8;
  logic [7:0] po8;

  always #1 clk = ~clk;   // 2 ns period, rising edges at 1, 3, 5, ...

  e_4_pipo u_dut (
    .clk(clk),
    .rst(rst),
    .pi (pi4),
    .po (po4)
  );

  e_4_pipo #(.WIDTH(4), .RESET_VALUE(RV)) u_dut_rv (
    .clk(clk),
    .rst(rst),
    .pi (pi4),
    .po (po_rv)
  );

  e_4_pipo #(.WIDTH(8), .RESET_VALUE(8'h00)) u_dut8 (
    .clk(clk),
    .rst(rst),
    .pi (pi8),
    .po (po8)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  logic [3:0] exp_q[$];
  logic [7:0] exp8_q[$];

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_po4"}, {4'h0, po4}, 8'h00);
    check_eq({tag, "_porv"}, {4'h0, po_rv}, {4'h0, RV});
    check_eq({tag, "_po8"}, po8, 8'h00);
  endtask

  // ---------------- driver tasks ----------------
  // Wait for the next rising edge and settle away from it.
  task automatic after_edge();
    @(posedge clk);
    #0.5;
  endtask

  // Pulse reset low for 1 ns starting 0.5 ns after an edge (edge-free window).
  task automatic reset_pulse(input string tag);
    rst = 1'b0;
    #0.3;
    check_reset_state({tag, "_low"});
    #0.7;
    rst = 1'b1;
    #0.2;
    check_reset_state({tag, "_rel"});
  endtask

  // Time-based sequence: value i is applied over [t0+5i, t0+5i+5).
  logic [3:0] seq_vals [3];
  realtime    t0;

  task automatic run_sequence();
    seq_vals[0] = 4'b1010;
    seq_vals[1] = 4'b1111;
    seq_vals[2] = 4'b0101;
    @(negedge clk);
    #0.5;
    t0 = $realtime;
    fork
      begin
        pi4 = seq_vals[0];
        #5 pi4 = seq_vals[1];
        #5 pi4 = seq_vals[2];
      end
      begin
        realtime te;
        int      idx;
        while ($realtime < t0 + 150.0) begin
          @(posedge clk);
          te  = $realtime;
          idx = $rtoi((te - t0) / 5.0);
          if (idx > 2) idx = 2;
          #0.5;
          check_eq("seq", {4'h0, po4}, {4'h0, seq_vals[idx]});
        end
      end
    join
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [3:0] keep4;
    logic [7:0] keep8;
    rst = 1'b1;
    pi4 = 4'h0;
    pi8 = 8'h00;

    // 1. Asynchronous reset mid-cycle with all-ones input.
    #0.5;
    pi4 = 4'b1111;
    pi8 = 8'hFF;
    rst = 1'b0;
    #0.3;
    check_reset_state("async_rst");
    repeat (3) begin
      after_edge();
      check_reset_state("rst_hold");
      pi4 = 4'($urandom_range(0, 15));
      pi8 = 8'($urandom_range(0, 255));
    end

    // 2. Release and load: nothing moves until the first edge.
    @(negedge clk);
    rst = 1'b1;
    pi4 = 4'b1010;
    pi8 = 8'hA5;
    #0.3;
    check_reset_state("pre_edge");
    after_edge();
    check_eq("load4", {4'h0, po4}, 8'h0A);
    check_eq("load_rv", {4'h0, po_rv}, 8'h0A);
    check_eq("load8", po8, 8'hA5);

    // 3. Held-value sequence, 5 ns per value, then constant for the rest.
    run_sequence();

    // 4. Glitch between edges, restored before the edge.
    @(negedge clk);
    pi4 = 4'b0101;
    #0.3 pi4 = 4'b1010;
    #0.2 check_eq("glitch_mid", {4'h0, po4}, 8'h05);
    #0.2 pi4 = 4'b0101;
    after_edge();
    check_eq("glitch_edge", {4'h0, po4}, 8'h05);

    // 5. Reset pulse mid-stream, then reload of a new input.
    pi4 = 4'b0011;
    pi8 = 8'h3C;
    reset_pulse("mid_rst");
    after_edge();
    check_eq("reload4", {4'h0, po4}, 8'h03);
    check_eq("reload_rv", {4'h0, po_rv}, 8'h03);
    check_eq("reload8", po8, 8'h3C);

    // Randomised phase: random words, random glitches, random reset pulses.
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      keep4 = 4'($urandom_range(0, 15));
      keep8 = 8'($urandom_range(0, 255));
      pi4 = keep4;
      pi8 = keep8;
      if ($urandom_range(0, 3) == 0) begin
        #0.3;
        pi4 = ~keep4;
        pi8 = 8'($urandom);
        #0.3;
        pi4 = keep4;
        pi8 = keep8;
      end
      exp_q.push_back(keep4);
      exp8_q.push_back(keep8);
      after_edge();
      keep4 = exp_q.pop_front();
      keep8 = exp8_q.pop_front();
      check_eq("rnd4", {4'h0, po4}, {4'h0, keep4});
      check_eq("rnd_rv", {4'h0, po_rv}, {4'h0, keep4});
      check_eq("rnd8", po8, keep8);
      if ($urandom_range(0, 7) == 0) begin
        reset_pulse("rnd_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
